// File: rtl/conv_overlap_add_if.sv
// conv_overlap_add_if
//   Stream bundle for the overlap-add stage.
//   Input side : in_valid / in_ready / in_data[31:0] / in_last (packed block word)
//   Output side: out_valid / out_ready / out_data[OUT_W-1:0] / out_last (samples)
//   master: the environment (drives input words, accepts samples)
//   slave : the overlap-add block
interface conv_overlap_add_if #(
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv_overlap_add.sv
// conv_overlap_add
//   Overlap-adds consecutive packed 4-tap convolution blocks (seven 4-bit
//   partial outputs y0..y6 per word) into one continuous sample stream.
//   Each block emits s0..s3 (y0..y2 plus carried tail, y3), keeps y4..y6 as
//   the tail for the next block, and flushes the tail after a last block.
//   Ports:
//     clk   - clock, all state on rising edge
//     rst_n - asynchronous active-low reset
//     bus   - conv_overlap_add_if.slave (input word stream, output sample stream)
//   Build option: define CONV_OA_SAT_EN to clamp emitted samples to 15.
module conv_overlap_add #(
    parameter int OUT_W = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    conv_overlap_add_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, EMIT, TAIL} state_e;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][4:0]  s_q, s_d;
    logic [2:0][3:0]  ov_q, ov_d;
    logic             last_q, last_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;

    logic             accept;
    logic             out_hs;
    logic [3:0][4:0]  sum;
    logic             unused_hi;

    assign unused_hi = ^bus.in_data[31:28];

    function automatic logic [OUT_W-1:0] fmt(input logic [4:0] v);
`ifdef CONV_OA_SAT_EN
        fmt = (v > 5'd15) ? OUT_W'(4'hF) : OUT_W'(v);
`else
        fmt = OUT_W'(v);
`endif
    endfunction

    assign accept = bus.in_valid && (state_q == IDLE);
    assign out_hs = bus.out_ready && (state_q != IDLE);

    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            sum[k] = {1'b0, bus.in_data[4*k +: 4]} + {1'b0, ov_q[k]};
        end
        sum[3] = {1'b0, bus.in_data[15:12]};
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = EMIT;
            EMIT: if (out_hs && idx_q == 2'd3) state_d = last_q ? TAIL : IDLE;
            TAIL: if (out_hs && idx_q == 2'd2) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: out_data is preloaded with the next sample at each handshake
    // so the output stays registered while streaming one sample per cycle.
    always_comb begin
        idx_d      = idx_q;
        s_d        = s_q;
        ov_d       = ov_q;
        last_d     = last_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    s_d        = sum;
                    ov_d       = bus.in_data[27:16];
                    last_d     = bus.in_last;
                    idx_d      = 2'd0;
                    out_data_d = fmt(sum[0]);
                end
            end
            EMIT: begin
                if (out_hs) begin
                    if (idx_q != 2'd3) begin
                        idx_d      = idx_q + 2'd1;
                        out_data_d = fmt(s_q[idx_q + 2'd1]);
                    end else begin
                        idx_d      = 2'd0;
                        out_data_d = last_q ? OUT_W'(ov_q[0]) : '0;
                    end
                end
            end
            TAIL: begin
                if (out_hs) begin
                    if (idx_q != 2'd2) begin
                        idx_d      = idx_q + 2'd1;
                        out_data_d = OUT_W'(ov_q[idx_q + 2'd1]);
                    end else begin
                        idx_d      = 2'd0;
                        ov_d       = '0;
                        out_data_d = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q != IDLE);
        bus.out_last  = (state_q == TAIL) && (idx_q == 2'd2);
        bus.out_data  = out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            s_q        <= '0;
            ov_q       <= '0;
            last_q     <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            s_q        <= s_d;
            ov_q       <= ov_d;
            last_q     <= last_d;
            out_data_q <= out_data_d;
        end
    end

endmodule
